// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the irq_ctrl interrupt controller.
// Register offsets, CTRL layout and sizing limits.
package irq_ctrl_pkg;

   localparam logic [2:0] IRQ_CTRL_REG_CTRL   = 3'd0;
   localparam logic [2:0] IRQ_CTRL_REG_STATE  = 3'd1;
   localparam logic [2:0] IRQ_CTRL_REG_MASK   = 3'd2;
   localparam logic [2:0] IRQ_CTRL_REG_SET    = 3'd3;
   localparam logic [2:0] IRQ_CTRL_REG_CLEAR  = 3'd4;
   localparam logic [2:0] IRQ_CTRL_REG_MODE   = 3'd5;
   localparam logic [2:0] IRQ_CTRL_REG_POL    = 3'd6;
   localparam logic [2:0] IRQ_CTRL_REG_VECTOR = 3'd7;

   localparam int IRQ_CTRL_CTRL_COR_BIT = 0;
   localparam int IRQ_CTRL_CTRL_GEN_BIT = 1;

   localparam int IRQ_CTRL_MAX_COUNT        = 32;
   localparam int IRQ_CTRL_VECTOR_VALID_BIT = 31;

   typedef struct packed {
      logic gen;
      logic cor;
   } irq_ctrl_ctrl_t;

endpackage

// File: rtl/irq_ctrl_sync.sv
// Single-line multi-flop synchroniser with asynchronous clear.
// Brings one asynchronous event line into the clk domain.
module irq_ctrl_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic nrst,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/irq_ctrl.sv
// Parametrised interrupt controller with an 8-register window.
// Define IRQ_CTRL_VECTOR_EN to enable the VECTOR priority encoder.
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int         IRQ_COUNT   = 8,
   parameter int         SYNC_STAGES = 2,
   parameter logic [6:0] BASE_ADDR   = 7'h02
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic [IRQ_COUNT-1:0] irq_lines,
   input  logic [6:0]           addr,
   input  logic [31:0]          wr_data,
   input  logic                 wr_en,
   input  logic                 rd_en,
   output logic [31:0]          rd_data,
   output logic                 irq_n,
   output logic [IRQ_COUNT-1:0] irq_pending
);

   localparam int N = IRQ_COUNT;

   irq_ctrl_ctrl_t ctrl_q, ctrl_d;
   logic [N-1:0]   mask_q, mask_d;
   logic [N-1:0]   mode_q, mode_d;
   logic [N-1:0]   pol_q, pol_d;
   logic [N-1:0]   pend_q, pend_d;
   logic [N-1:0]   prev_q;
   logic [N-1:0]   sync_w, line_w, ev_w;
   logic [N-1:0]   set_w, clr_w;
   logic [31:0]    rd_data_q, rd_data_d;
   logic [31:0]    vec_w;
   logic           irq_n_q, irq_n_d;
   logic [7:0]     rel_w;
   logic [2:0]     off_w;
   logic           in_win_w, wr_hit_w, rd_hit_w;
   logic           unused_w;

   assign unused_w = ^wr_data;

   for (genvar g = 0; g < N; g++) begin : g_sync
      irq_ctrl_sync #(
         .SYNC_STAGES(SYNC_STAGES)
      ) u_sync (
         .clk (clk),
         .nrst(nrst),
         .d_i (irq_lines[g]),
         .q_o (sync_w[g])
      );
   end

   // 8-bit subtraction so addresses below the base wrap out of range
   assign rel_w    = {1'b0, addr} - {1'b0, BASE_ADDR};
   assign in_win_w = (rel_w < 8'd8);
   assign off_w    = rel_w[2:0];
   assign wr_hit_w = wr_en & in_win_w;
   assign rd_hit_w = rd_en & in_win_w;

   assign line_w = sync_w ^ pol_q;
   assign ev_w   = (mode_q & line_w) | (~mode_q & line_w & ~prev_q);

`ifdef IRQ_CTRL_VECTOR_EN
   logic [N-1:0] act_w;
   assign act_w = pend_q & mask_q;

   always_comb begin
      vec_w = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (act_w[i]) begin
            vec_w[4:0]                       = 5'(i);
            vec_w[IRQ_CTRL_VECTOR_VALID_BIT] = 1'b1;
         end
      end
   end
`else
   assign vec_w = '0;
`endif

   always_comb begin
      ctrl_d = ctrl_q;
      mask_d = mask_q;
      mode_d = mode_q;
      pol_d  = pol_q;
      set_w  = '0;
      clr_w  = '0;
      if (wr_hit_w) begin
         unique case (off_w)
            IRQ_CTRL_REG_CTRL:  ctrl_d = wr_data[1:0];
            IRQ_CTRL_REG_MASK:  mask_d = wr_data[N-1:0];
            IRQ_CTRL_REG_SET:   set_w  = wr_data[N-1:0];
            IRQ_CTRL_REG_CLEAR: clr_w  = wr_data[N-1:0];
            IRQ_CTRL_REG_MODE:  mode_d = wr_data[N-1:0];
            IRQ_CTRL_REG_POL:   pol_d  = wr_data[N-1:0];
            default: ;
         endcase
      end
      // clear-on-read drops exactly the bits this read returns
      if (rd_hit_w && off_w == IRQ_CTRL_REG_STATE && ctrl_q.cor) begin
         clr_w = clr_w | pend_q;
      end
   end

   assign pend_d  = (pend_q & ~clr_w) | set_w | ev_w;
   assign irq_n_d = ~(ctrl_q.gen & |(pend_q & mask_q));

   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = '0;
         if (in_win_w) begin
            unique case (off_w)
               IRQ_CTRL_REG_CTRL:   rd_data_d = {30'd0, ctrl_q};
               IRQ_CTRL_REG_STATE:  rd_data_d = 32'(pend_q);
               IRQ_CTRL_REG_MASK:   rd_data_d = 32'(mask_q);
               IRQ_CTRL_REG_MODE:   rd_data_d = 32'(mode_q);
               IRQ_CTRL_REG_POL:    rd_data_d = 32'(pol_q);
               IRQ_CTRL_REG_VECTOR: rd_data_d = vec_w;
               default:             rd_data_d = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         ctrl_q    <= '0;
         mask_q    <= '0;
         mode_q    <= '0;
         pol_q     <= '0;
         pend_q    <= '0;
         prev_q    <= '0;
         rd_data_q <= '0;
         irq_n_q   <= 1'b1;
      end else begin
         ctrl_q    <= ctrl_d;
         mask_q    <= mask_d;
         mode_q    <= mode_d;
         pol_q     <= pol_d;
         pend_q    <= pend_d;
         prev_q    <= line_w;
         rd_data_q <= rd_data_d;
         irq_n_q   <= irq_n_d;
      end
   end

   assign rd_data     = rd_data_q;
   assign irq_n       = irq_n_q;
   assign irq_pending = pend_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus
// randomized traffic compared against a behavioural model.
module tb_irq_ctrl;

   localparam int         N    = 8;
   localparam int         S    = 2;
   localparam logic [6:0] BASE = 7'h02;

   logic        clk = 1'b0;
   logic        nrst = 1'b1;
   logic [7:0]  irq_lines;
   logic [6:0]  addr;
   logic [31:0] wr_data;
   logic        wr_en, rd_en;
   logic [31:0] rd_data;
   logic        irq_n;
   logic [7:0]  irq_pending;

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   irq_ctrl #(
      .IRQ_COUNT  (N),
      .SYNC_STAGES(S),
      .BASE_ADDR  (BASE)
   ) dut (
      .clk        (clk),
      .nrst       (nrst),
      .irq_lines  (irq_lines),
      .addr       (addr),
      .wr_data    (wr_data),
      .wr_en      (wr_en),
      .rd_en      (rd_en),
      .rd_data    (rd_data),
      .irq_n      (irq_n),
      .irq_pending(irq_pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // behavioural model: input history queue and register image
   logic [7:0]  hist[$];
   logic [1:0]  m_ctrl;
   logic [7:0]  m_mask, m_mode, m_pol, m_pend, m_prev;
   logic [31:0] m_rd;
   logic        m_irqn;
   logic [7:0]  t_lq, t_ev, t_set, t_clr;
   int          t_rel;

   function automatic logic [31:0] vec_of(input logic [7:0] a);
`ifdef IRQ_CTRL_VECTOR_EN
      for (int i = 0; i < 8; i++)
         if (a[i]) return {1'b1, 26'd0, 5'(i)};
`endif
      return 32'h0;
   endfunction

   always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         hist.delete();
         for (int i = 0; i < S; i++) hist.push_back(8'h00);
         m_ctrl = 0; m_mask = 0; m_mode = 0; m_pol = 0;
         m_pend = 0; m_prev = 0; m_rd = 0; m_irqn = 1'b1;
      end else begin
         t_lq = hist[0] ^ m_pol;
         for (int i = 0; i < 8; i++)
            t_ev[i] = m_mode[i] ? t_lq[i] : (t_lq[i] && !m_prev[i]);
         t_set = 0;
         t_clr = 0;
         t_rel = int'(addr) - int'(BASE);
         m_irqn = !(m_ctrl[1] && ((m_pend & m_mask) != 0));
         if (rd_en) begin
            m_rd = 0;
            case (t_rel)
               0: m_rd = {30'd0, m_ctrl};
               1: begin
                  m_rd = {24'd0, m_pend};
                  if (m_ctrl[0]) t_clr = m_pend;
               end
               2: m_rd = {24'd0, m_mask};
               5: m_rd = {24'd0, m_mode};
               6: m_rd = {24'd0, m_pol};
               7: m_rd = vec_of(m_pend & m_mask);
               default: m_rd = 0;
            endcase
         end
         if (wr_en) begin
            case (t_rel)
               0: m_ctrl = wr_data[1:0];
               2: m_mask = wr_data[7:0];
               3: t_set = wr_data[7:0];
               4: t_clr = t_clr | wr_data[7:0];
               5: m_mode = wr_data[7:0];
               6: m_pol = wr_data[7:0];
               default: ;
            endcase
         end
         m_pend = (m_pend & ~t_clr) | t_set | t_ev;
         m_prev = t_lq;
         hist.push_back(irq_lines);
         void'(hist.pop_front());
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         chk("irq_n", {31'd0, irq_n}, {31'd0, m_irqn});
         chk("irq_pending", {24'd0, irq_pending}, {24'd0, m_pend});
         chk("rd_data", rd_data, m_rd);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] off, input logic [31:0] d);
      addr = BASE + 7'(off);
      wr_data = d;
      wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic rd(input logic [2:0] off, output logic [31:0] d);
      addr = BASE + 7'(off);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      d = rd_data;
   endtask

   logic [31:0] rv;
   logic [31:0] exp_rst[8];

   initial begin
      irq_lines = 8'hFF;
      addr = 0;
      wr_data = 0;
      wr_en = 0;
      rd_en = 0;
      #2 nrst = 1'b0;
      #1 mon_en = 1'b1;
      #20;
      chk("rst irq_n", {31'd0, irq_n}, 32'h1);
      chk("rst rd_data", rd_data, 32'h0);
      chk("rst pending", {24'd0, irq_pending}, 32'h0);
      @(negedge clk);
      nrst = 1'b1;
      repeat (5) tick();
      exp_rst = '{32'h0, 32'hFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
      for (int i = 0; i < 8; i++) begin
         rd(3'(i), rv);
         chk($sformatf("post-rst reg%0d", i), rv, exp_rst[i]);
      end
      rd(3'd0, rv);
      addr = 7'h01;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("out-of-window read", rd_data, 32'h0);

      irq_lines = 8'h00;
      repeat (3) tick();
      wr(3'd4, 32'hFF);
      wr(3'd2, 32'h01);
      wr(3'd0, 32'h2);
      tick();
      // edge latency
      irq_lines[0] = 1'b1;
      tick();
      irq_lines[0] = 1'b0;
      tick();
      chk("edge t+2 pending", {31'd0, irq_pending[0]}, 32'h0);
      tick();
      chk("edge t+3 pending", {31'd0, irq_pending[0]}, 32'h1);
      chk("edge t+3 irq_n", {31'd0, irq_n}, 32'h1);
      tick();
      chk("edge t+4 irq_n", {31'd0, irq_n}, 32'h0);
      wr(3'd4, 32'h01);
      chk("clear w+1 irq_n", {31'd0, irq_n}, 32'h0);
      tick();
      chk("clear w+2 irq_n", {31'd0, irq_n}, 32'h1);

      // level mode with inverted polarity
      wr(3'd5, 32'h04);
      wr(3'd6, 32'h04);
      repeat (3) tick();
      wr(3'd4, 32'h04);
      tick();
      rd(3'd1, rv);
      chk("level clear held", rv, 32'h04);
      irq_lines[2] = 1'b1;
      repeat (3) tick();
      wr(3'd4, 32'h04);
      rd(3'd1, rv);
      chk("level clear inactive", rv, 32'h00);
      irq_lines[2] = 1'b0;
      repeat (3) tick();
      wr(3'd6, 32'h00);
      wr(3'd5, 32'h00);
      wr(3'd4, 32'hFF);
      tick();

      // clear-on-read collision with an edge on line 5
      wr(3'd0, 32'h3);
      wr(3'd3, 32'h03);
      irq_lines[5] = 1'b1;
      tick();
      tick();
      rd(3'd1, rv);
      chk("cor read", rv, 32'h03);
      irq_lines[5] = 1'b0;
      rd(3'd1, rv);
      chk("cor next read", rv, 32'h20);
      wr(3'd0, 32'h2);

      // software set with mask gating
      wr(3'd2, 32'h00);
      wr(3'd3, 32'h80);
      tick();
      chk("masked set irq_n", {31'd0, irq_n}, 32'h1);
      wr(3'd2, 32'h80);
      tick();
      chk("unmasked irq_n", {31'd0, irq_n}, 32'h0);
      rd(3'd7, rv);
`ifdef IRQ_CTRL_VECTOR_EN
      chk("vector", rv, 32'h80000007);
`else
      chk("vector", rv, 32'h0);
`endif
      wr(3'd4, 32'hFF);

      // asynchronous reset mid-operation
      wr(3'd3, 32'hFF);
      wr(3'd2, 32'hFF);
      tick();
      tick();
      chk("pre-reset irq_n", {31'd0, irq_n}, 32'h0);
      chk("pre-reset pending", {24'd0, irq_pending}, 32'hFF);
      #3 nrst = 1'b0;
      #1;
      chk("async irq_n", {31'd0, irq_n}, 32'h1);
      chk("async pending", {24'd0, irq_pending}, 32'h0);
      chk("async rd_data", rd_data, 32'h0);
      @(negedge clk);
      nrst = 1'b1;
      repeat (4) tick();

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         irq_lines ^= 8'($urandom) & 8'($urandom) & 8'($urandom);
         addr = BASE - 7'd1 + 7'($urandom_range(0, 9));
         wr_data = $urandom;
         wr_en = ($urandom_range(0, 3) == 0);
         rd_en = ($urandom_range(0, 2) == 0);
         if (wr_en && addr == BASE + 7'd4 && $urandom_range(0, 1) == 0)
            wr_data = 32'h0;
         tick();
      end
      wr_en = 1'b0;
      rd_en = 1'b0;
      tick();
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Parametrised interrupt controller; next generation of the single-line IRQ logic in the gpsdo top level.
- Takes IRQ_COUNT asynchronous event lines and synchronises them.
- Per line: edge or level mode, polarity, pending state, mask, software set/clear.
- Exposes a register window on the spi_slave addr/data/wr_en/rd_en bus and drives the active-low IRQ pin to the SMC.

Parameters:
- IRQ_COUNT, 8, number of IRQ lines, legal range 1..32.
- SYNC_STAGES, 2, synchroniser flops per line, minimum 2.
- BASE_ADDR, 7'h02, first register address of the 8-register window.

Ports:
- clk  input  1  module clock (CLK1 domain).
- nrst  input  1  reset, asynchronous, active-low.
- irq_lines  input  IRQ_COUNT  raw event lines, asynchronous to clk.
- addr  input  7  register address from spi_slave.
- wr_data  input  32  write data.
- wr_en  input  1  single-cycle write strobe.
- rd_en  input  1  single-cycle read strobe.
- rd_data  output  32  registered read data.
- irq_n  output  1  registered interrupt request to SMC, active-low.
- irq_pending  output  IRQ_COUNT  raw pending vector, for debug/LED use.

Behaviour:
- Clocking and reset: one clock, clk. nrst asserted (low) asynchronously clears all flops: CTRL, MASK, MODE, POL, pending, edge history and synchroniser stages. Outputs during reset: rd_data=0, irq_n=1, irq_pending=0.
- Register map, relative to BASE_ADDR; unused upper bits read 0:
  - +0 CTRL RW: bit0 clear_on_read, bit1 global_en.
  - +1 STATE RO: pending vector.
  - +2 MASK RW.
  - +3 SET W1S, reads 0.
  - +4 CLEAR W1C, reads 0.
  - +5 MODE RW: 1=level, 0=edge.
  - +6 POL RW: 1=inverted input.
  - +7 VECTOR RO.
  - Addresses outside the window: writes are ignored, reads return 0.
- Input path: line_q = synchronised irq_lines XOR POL.
  - Edge mode: an event is line_q & ~line_prev. line_prev is updated every cycle.
  - Level mode: an event is line_q, held for as long as it stays high.
- Pending update, per bit, every cycle: pending <= (pending & ~clr) | set | event.
  - clr = CLEAR write bits, or the clear_on_read clear.
  - set = SET write bits.
  - A hardware event in the same cycle as a clear wins, so no event is lost.
  - In level mode, clearing an active line has no lasting effect.
- Latency: a line toggled synchronously at cycle t sets pending at t+SYNC_STAGES+1. irq_n goes low at t+SYNC_STAGES+2, provided mask=1 and global_en=1.
- irq_n <= ~(global_en & |(pending & MASK)). It is registered with one cycle of latency. MASK and global_en only gate the output; masked lines still latch pending.
- Reads: rd_data is updated on the cycle after rd_en and holds its value until the next rd_en.
  - A STATE read with clear_on_read=1 clears exactly the bits returned. This applies one cycle after rd_en, with the same event-wins rule.
- Writes take effect on the cycle after wr_en. Concurrent wr_en and rd_en to different registers are both honoured.
- Reset release: edge history starts at 0. A line already active at release registers one edge event; the default MASK=0 keeps irq_n high.
- POL change: a change that produces a rising line_q in edge mode is a valid edge and latches pending.

Optional Feature:
- Macro: IRQ_CTRL_VECTOR_EN.
- Defined:
  - VECTOR (+7) returns {valid, 26'd0, idx[4:0]}, with valid in bit31.
  - idx = lowest-numbered bit of pending & MASK; valid=1 when any such bit is set.
  - The vector is computed combinationally and sampled on rd_en.
- Undefined: VECTOR reads 32'h0 and no priority encoder is synthesised.

Decomposition:
- Package irq_ctrl_pkg:
  - Register offset constants IRQ_CTRL_REG_CTRL through IRQ_CTRL_REG_VECTOR (3'd0..3'd7).
  - CTRL bit positions.
  - Constants IRQ_CTRL_MAX_COUNT=32 and IRQ_CTRL_VECTOR_VALID_BIT=31.
- Sub-module irq_ctrl_sync: one line's SYNC_STAGES-deep synchroniser with async clear, instantiated as an IRQ_COUNT array. The edge detector and pending flop remain in the parent.

Test Plan (IRQ_COUNT=8, SYNC_STAGES=2, BASE_ADDR=7'h02):
- Reset levels: nrst low with irq_lines=8'hFF -> irq_n=1, rd_data=0, irq_pending=0. After release, all registers read 0 except STATE=8'hFF.
- Edge latency: with MASK=8'h01 and CTRL=2'b10, pulse irq_lines[0] high for one cycle at t -> irq_pending[0]=1 at t+3, irq_n=0 at t+4. After CLEAR=8'h01, irq_n=1 two cycles after wr_en.
- Level mode and polarity: with MODE=8'h04, POL=8'h04 and irq_lines[2] held low, CLEAR=8'h04 -> STATE still reads 8'h04. Raising irq_lines[2] and then clearing -> STATE=8'h00.
- Clear-on-read collision: CTRL=2'b11 and STATE=8'h03, read STATE with an edge on line 5 arriving in the clear cycle -> read returns 8'h03, next STATE read returns 8'h20.
- Software set and mask: SET=8'h80 with MASK=0 -> irq_n stays 1. Then MASK=8'h80 -> irq_n=0. VECTOR reads 32'h80000007 with IRQ_CTRL_VECTOR_EN defined and 32'h0 without it.
- Async reset mid-operation: assert nrst with STATE=8'hFF and irq_n=0 -> irq_n=1 and irq_pending=0 in the same cycle, without waiting for a clk edge.
